// File: rtl/apbdma_pkg.sv
// apbdma_pkg: shared types and helpers for the APB DMA backend.
//   state_t      - APB initiator FSM states
//   BeatCntWidth - width of the remaining-beat counter (255 bytes at NB=1 -> 255 beats)
//   strobe_en()  - per-lane write strobe enable for the last (possibly partial) beat
package apbdma_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_W = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    WAIT_R = 3'd4
  } state_t;

  localparam int BeatCntWidth = 9;

  // A lane is enabled on every beat except the tail of a partial last beat,
  // where only the lanes below last_bytes carry data.
  function automatic logic strobe_en(input int unsigned lane,
                                     input logic [7:0] last_bytes,
                                     input logic last_beat);
    logic en;
    if (last_beat && (last_bytes != 8'd0)) begin
      en = (lane < {24'd0, last_bytes});
    end else begin
      en = 1'b1;
    end
    return en;
  endfunction

endpackage

// File: rtl/apbdma_timeout_cnt.sv
// apbdma_timeout_cnt: pready watchdog for the APB DMA initiator.
// Only instantiated when APBDMA_TIMEOUT_EN is defined.
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   clear_i      - restart the count (driven while the FSM is in SETUP)
//   run_i        - count this cycle (driven while the FSM is in ACCESS)
//   expired_o    - high in the TimeoutCycles-th consecutive ACCESS cycle
module apbdma_timeout_cnt #(
  parameter int TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CntWidth = $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] cnt_r;

  // ACCESS cycle counter; saturates so a stuck FSM cannot wrap it back to zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (clear_i) begin
      cnt_r <= '0;
    end else if (run_i && (cnt_r != CntWidth'(TimeoutCycles))) begin
      cnt_r <= cnt_r + CntWidth'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // cnt_r holds the number of ACCESS cycles already elapsed, so this fires in the last allowed one
  assign expired_o = run_i && (cnt_r == CntWidth'(TimeoutCycles - 1));

endmodule

// File: rtl/apbdma_apb_master.sv
// apbdma_apb_master: APB4 initiator backend of the APB DMA.
// Accepts a start command (address, byte count, direction) and either drains
// W FIFO beats into APB writes or performs APB reads and pushes the words
// into the R FIFO. Every beat takes at least 3 cycles.
// Optional feature: define APBDMA_TIMEOUT_EN to abort an ACCESS phase that
// sees no pready_i within TimeoutCycles cycles (sets err_o).
// Ports:
//   clk_i, rst_i                          - clock, asynchronous active-high reset
//   start_i, start_addr_i, num_bytes_i, rw_i - command from config registers
//   busy_o, err_o                         - status (err_o sticky until next start)
//   w_data_i, w_strb_i, w_valid_i, w_ready_o - W FIFO pop side
//   r_data_o, r_valid_o, r_ready_i        - R FIFO push side
//   paddr_o .. pstrb_o / pready_i .. pslverr_i - APB4 master port
module apbdma_apb_master
  import apbdma_pkg::*;
#(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   start_addr_i,
  input  logic [7:0]             num_bytes_i,
  input  logic                   rw_i,
  output logic                   busy_o,
  output logic                   err_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic [2:0]             pprot_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  input  logic                   pready_i,
  input  logic [DataWidth-1:0]   prdata_i,
  input  logic                   pslverr_i
);

  localparam int NB    = DataWidth / 8;
  localparam int LogNb = $clog2(NB);
  localparam logic [AddrWidth-1:0] AddrMask = AddrWidth'(NB - 1);

  state_t                  state_r, state_next_s;
  logic [AddrWidth-1:0]    addr_r;
  logic [BeatCntWidth-1:0] beats_r;
  logic [7:0]              last_bytes_r;
  logic                    rw_r, err_r;
  logic                    busy_r, psel_r, penable_r, pwrite_r, w_ready_r, r_valid_r;
  logic [DataWidth-1:0]    wdata_r, rdata_r;
  logic [NB-1:0]           pstrb_r, mask_s;
  logic                    accept_s, pop_s, beat_done_s, err_set_s, capture_s;
  logic                    last_beat_s, rw_next_s, timeout_s;
  logic [BeatCntWidth-1:0] beats_init_s;

  assign last_beat_s  = (beats_r == BeatCntWidth'(1));
  assign rw_next_s    = accept_s ? rw_i : rw_r;
  // ceil(num_bytes / NB); the 9-bit sum cannot overflow for NB <= 128
  assign beats_init_s = ({1'b0, num_bytes_i} + BeatCntWidth'(NB - 1)) >> LogNb;

`ifdef APBDMA_TIMEOUT_EN
  apbdma_timeout_cnt #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_r == SETUP),
    .run_i     (state_r == ACCESS),
    .expired_o (timeout_s)
  );
`else
  // No watchdog: ACCESS waits for pready_i indefinitely
  assign timeout_s = (TimeoutCycles < 0);
`endif

  // Strobe mask for the beat being popped from the W FIFO
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < NB; i++) begin
      mask_s[i] = strobe_en(i, last_bytes_r, last_beat_s);
    end
  end

  // Next-state decode and per-cycle datapath strobes
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    pop_s        = 1'b0;
    beat_done_s  = 1'b0;
    err_set_s    = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i && (num_bytes_i != 8'd0)) begin
          accept_s     = 1'b1;
          state_next_s = rw_i ? WAIT_W : SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_W: begin
        if (w_valid_i) begin
          pop_s        = 1'b1;
          state_next_s = SETUP;
        end else begin
          state_next_s = WAIT_W;
        end
      end
      SETUP: begin
        state_next_s = ACCESS;
      end
      ACCESS: begin
        // pready_i in the final watchdog cycle still completes the beat
        if (pready_i) begin
          if (pslverr_i) begin
            err_set_s    = 1'b1;
            state_next_s = IDLE;
          end else if (rw_r) begin
            beat_done_s  = 1'b1;
            state_next_s = last_beat_s ? IDLE : WAIT_W;
          end else begin
            capture_s    = 1'b1;
            state_next_s = WAIT_R;
          end
        end else if (timeout_s) begin
          err_set_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = ACCESS;
        end
      end
      WAIT_R: begin
        if (r_ready_i) begin
          beat_done_s  = 1'b1;
          state_next_s = last_beat_s ? IDLE : SETUP;
        end else begin
          state_next_s = WAIT_R;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register and control outputs, registered from the next state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      w_ready_r <= 1'b0;
      r_valid_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      busy_r    <= (state_next_s != IDLE);
      psel_r    <= (state_next_s == SETUP) || (state_next_s == ACCESS);
      penable_r <= (state_next_s == ACCESS);
      pwrite_r  <= rw_next_s && ((state_next_s == SETUP) || (state_next_s == ACCESS));
      w_ready_r <= (state_next_s == WAIT_W);
      r_valid_r <= (state_next_s == WAIT_R);
    end
  end

  // Transfer context, beat data and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_r       <= '0;
      beats_r      <= '0;
      last_bytes_r <= 8'd0;
      rw_r         <= 1'b0;
      err_r        <= 1'b0;
      wdata_r      <= '0;
      rdata_r      <= '0;
      pstrb_r      <= '0;
    end else begin
      if (accept_s) begin
        addr_r       <= start_addr_i & ~AddrMask;
        beats_r      <= beats_init_s;
        last_bytes_r <= num_bytes_i & 8'(NB - 1);
        rw_r         <= rw_i;
        pstrb_r      <= '0;
      end else if (beat_done_s) begin
        addr_r  <= addr_r + AddrWidth'(NB);
        beats_r <= beats_r - BeatCntWidth'(1);
      end else if (pop_s) begin
        wdata_r <= w_data_i;
        pstrb_r <= w_strb_i & mask_s;
      end
      if (capture_s) begin
        rdata_r <= prdata_i;
      end
      if (accept_s) begin
        err_r <= 1'b0;
      end else if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign busy_o    = busy_r;
  assign err_o     = err_r;
  assign w_ready_o = w_ready_r;
  assign r_data_o  = rdata_r;
  assign r_valid_o = r_valid_r;
  assign paddr_o   = addr_r;
  assign pprot_o   = 3'b000;
  assign psel_o    = psel_r;
  assign penable_o = penable_r;
  assign pwrite_o  = pwrite_r;
  assign pwdata_o  = wdata_r;
  assign pstrb_o   = pstrb_r;

endmodule

// File: doc/apbdma_apb_master.md
Name: apbdma_apb_master

Overview:
APB initiator (backend) of the APB DMA. It takes a start command (address, byte count, direction) from the config registers. It drains write beats from the W FIFO into APB write transfers on the master port, or performs APB reads and pushes the returned words into the R FIFO. `busy_o` reports activity back to the config block, which sees it through a 3-stage synchroniser.

Parameters:
- AddrWidth, 32, APB master address width
- DataWidth, 32, APB data width; must be a power of two and at least 8; NB = DataWidth/8 bytes per beat
- TimeoutCycles, 1024, pready watchdog limit; used only with APBDMA_TIMEOUT_EN

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start pulse, sampled only in IDLE
- start_addr_i  in  AddrWidth  first beat byte address
- num_bytes_i  in  8  transfer length in bytes, 1..255; 0 means no transfer
- rw_i  in  1  1 = write (W FIFO to APB), 0 = read (APB to R FIFO)
- busy_o  out  1  high while not IDLE
- err_o  out  1  sticky error flag
- w_data_i  in  DataWidth  write beat data
- w_strb_i  in  NB  write beat strobes
- w_valid_i  in  1  W FIFO not empty
- w_ready_o  out  1  pop W FIFO
- r_data_o  out  DataWidth  read beat to R FIFO
- r_valid_o  out  1  read beat valid
- r_ready_i  in  1  R FIFO not full
- paddr_o, pprot_o(3), psel_o, penable_o, pwrite_o, pwdata_o(DataWidth), pstrb_o(NB)  out  APB4 request
- pready_i, prdata_i(DataWidth), pslverr_i  in  APB4 response

Behaviour:
- Reset
  - All outputs 0; state IDLE; counters cleared.
  - Reset mid-transfer drops psel_o, penable_o, w_ready_o and r_valid_o asynchronously; the transfer is lost.
- Start acceptance
  - Condition: state IDLE, start_i = 1 and num_bytes_i != 0. start_i in any other state, or with num_bytes_i = 0, is ignored.
  - On accept, latch addr = start_addr_i with log2(NB) LSBs forced to 0.
  - Latch beats = ceil(num_bytes_i/NB) into a 9-bit counter.
  - Latch last_bytes = num_bytes_i mod NB, where 0 means a full beat.
  - Latch the direction; clear err_o.
- busy_o = (state != IDLE). It is registered and rises the cycle after accept.
- pprot_o is always 0.
- paddr_o = addr, incremented by NB after each completed beat; wraps modulo 2^AddrWidth.
- Write path:
  - WAIT_W:
    - w_ready_o = 1. On w_valid_i, latch data and pstrb = w_strb_i & mask, then go to SETUP.
    - mask is all-ones except on the last beat with last_bytes != 0, where it is (1<<last_bytes)-1.
  - SETUP: psel_o = 1, penable_o = 0, pwrite_o = 1; one cycle, then ACCESS.
  - ACCESS:
    - psel_o = 1 and penable_o = 1; all request signals held stable until pready_i.
    - On pready_i: if last beat go to IDLE, else go to WAIT_W.
- Read path:
  - SETUP: pwrite_o = 0, pstrb_o = 0.
  - ACCESS: on pready_i, capture prdata_i into r_data_o and go to WAIT_R.
  - WAIT_R:
    - r_valid_o = 1 until r_ready_i. psel_o stays low.
    - On handshake: if last beat go to IDLE, else go to SETUP.
    - The full word is always pushed, including on a partial last beat.
- Error
  - pready_i with pslverr_i in ACCESS sets err_o and goes directly to IDLE.
  - No R push for the failing beat. Remaining W beats are left in the FIFO for software to flush.
- Throughput: minimum 3 cycles per beat in either direction. Back-to-back beats never merge SETUP into the previous ACCESS.
- w_ready_o is asserted only in WAIT_W. r_valid_o is asserted only in WAIT_R.

Optional Feature:
- Macro APBDMA_TIMEOUT_EN.
- When defined:
  - A counter runs during ACCESS and is cleared on each SETUP.
  - Reaching TimeoutCycles without pready_i drops psel_o/penable_o, sets err_o and goes to IDLE.
- When undefined: no counter; ACCESS waits indefinitely. TimeoutCycles is unused.

Decomposition:
- apbdma_pkg:
  - state enum {IDLE, WAIT_W, SETUP, ACCESS, WAIT_R}
  - beat-count width localparam (9)
  - strobe-mask function
- The core FSM lives in apbdma_apb_master.
- One natural sub-module: apbdma_timeout_cnt, instantiated only under APBDMA_TIMEOUT_EN.

Test Plan:
All cases use DataWidth = 32.
1. Write, start_addr 0x100, num_bytes 8, W FIFO preloaded -> two APB writes to 0x100 and 0x104, pstrb 0xF each; busy_o falls the cycle after the second pready.
2. Write, start_addr 0x203, num_bytes 6 -> paddr 0x200, 0x204; second beat pstrb 0x3 with w_strb_i = 0xF.
3. Read, start_addr 0x40, num_bytes 12, pready delayed 2 cycles, r_ready_i low 3 cycles on beat 1 -> three ordered R pushes; psel_o stays low until each R handshake.
4. 4-beat write with pslverr_i on beat 2 -> err_o = 1, IDLE, beats 3-4 not popped; a new accepted start clears err_o.
5. Ignored starts:
   - start_i with num_bytes_i = 0 -> no psel_o, busy_o stays 0.
   - start_i during a transfer -> no effect on paddr or count.
6. rst_i asserted in ACCESS -> psel_o/penable_o low in the same cycle. With APBDMA_TIMEOUT_EN and TimeoutCycles = 16, pready_i held low -> err_o = 1 after 16 ACCESS cycles.
